// File: rtl/id_stage_hs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_hs_if : IF -> ID fetch bus (valid/ready handshake)          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface id_stage_hs_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  if_valid_i;
  logic [DATA_WIDTH-1:0] instr_i;
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  id_ready_o;

  modport master (output if_valid_i, instr_i, pc_i, input id_ready_o);
  modport slave  (input if_valid_i, instr_i, pc_i, output id_ready_o);
endinterface
`default_nettype wire

// File: rtl/id_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_hs : FIFO-buffered decode stage with valid/ready handshake, |
// |               load-use interlock and the ID/EX pipeline register.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_stage_hs #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM_WIDTH  = 8,
  parameter int REG_WIDTH  = 4,
  parameter int OP_WIDTH   = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   flush_i,
  id_stage_hs_if.slave          fetch,
  output logic [REG_WIDTH-1:0]  rf_r1_o,
  output logic [REG_WIDTH-1:0]  rf_r2_o,
  output logic                  jump_o,
  output logic [IMM_WIDTH-1:0]  jump_addr_o,
  output logic                  stop_o,
  output logic                  ex_valid_o,
  input  wire                   ex_ready_i,
  output logic [ADDR_WIDTH-1:0] pcE,
  output logic [REG_WIDTH-1:0]  rsE,
  output logic [REG_WIDTH-1:0]  rtE,
  output logic [REG_WIDTH-1:0]  rdE,
  output logic [IMM_WIDTH-1:0]  imm8E,
  output logic                  RegWriteE,
  output logic [1:0]            ALUopE,
  output logic                  BranchE,
  output logic                  MemReadE,
  output logic                  RegDstE,
  output logic                  MemWriteE,
  output logic                  MemToRegE,
  output logic                  MovE,
  output logic                  FloatingE
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_MOV  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_FADD = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_STOP = OP_WIDTH'(15);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_to_reg;
    logic       mov;
    logic       floating;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                mem_q [BUF_DEPTH];
  entry_t                mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  id_ready_q, id_ready_d;
  logic                  stop_q, stop_d;
  logic                  ex_valid_q, ex_valid_d;
  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [ADDR_WIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [REG_WIDTH-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [IMM_WIDTH-1:0]  ex_imm_q, ex_imm_d;

  entry_t                head;
  logic                  head_valid;
  logic [OP_WIDTH-1:0]   head_op;
  logic [REG_WIDTH-1:0]  head_rs, head_rt, head_rd;
  logic [IMM_WIDTH-1:0]  head_imm;
  ctrl_t                 dec_ctrl;
  logic                  dec_jump, dec_stop, dec_rtype;
  logic                  adv, haz, issue, push;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign head_op    = head.instr[DATA_WIDTH-1 -: OP_WIDTH];
  assign head_rs    = head.instr[2*REG_WIDTH +: REG_WIDTH];
  assign head_rt    = head.instr[REG_WIDTH +: REG_WIDTH];
  assign head_rd    = head.instr[0 +: REG_WIDTH];
  assign head_imm   = head.instr[0 +: IMM_WIDTH];

  // Control decode of the FIFO head (R-type ops read both rs and rt).
  always_comb begin
    dec_ctrl  = '0;
    dec_jump  = 1'b0;
    dec_stop  = 1'b0;
    dec_rtype = 1'b0;
    case (head_op)
      OP_ADD:  begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = 2'b10; dec_ctrl.reg_dst = 1'b1; dec_rtype = 1'b1; end
      OP_SUB:  begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = 2'b11; dec_ctrl.reg_dst = 1'b1; dec_rtype = 1'b1; end
      OP_ADDI: begin dec_ctrl.reg_write = 1'b1; end
      OP_LW:   begin dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_read = 1'b1; dec_ctrl.mem_to_reg = 1'b1; end
      OP_SW:   begin dec_ctrl.mem_write = 1'b1; end
      OP_BEQ:  begin dec_ctrl.branch = 1'b1; dec_ctrl.alu_op = 2'b01; end
      OP_JMP:  begin dec_jump = 1'b1; end
      OP_MOV:  begin dec_ctrl.reg_write = 1'b1; dec_ctrl.reg_dst = 1'b1; dec_ctrl.mov = 1'b1; end
      OP_FADD: begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = 2'b10; dec_ctrl.reg_dst = 1'b1;
                     dec_ctrl.floating = 1'b1; dec_rtype = 1'b1; end
      OP_STOP: begin dec_stop = 1'b1; end
      default: ;
    endcase
  end

  assign adv   = !ex_valid_q || ex_ready_i;
  assign haz   = head_valid && ex_valid_q && ex_ctrl_q.mem_read &&
                 ((ex_rt_q == head_rs) || (dec_rtype && (ex_rt_q == head_rt)));
  assign issue = adv && head_valid && !haz && !stop_q;
  assign push  = fetch.if_valid_i && id_ready_q;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    stop_d     = stop_q;
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_pc_d    = ex_pc_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_rd_d    = ex_rd_q;
    ex_imm_d   = ex_imm_q;
    if (flush_i) begin
      // Redirect wins over any same-cycle push or issue.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: fetch.instr_i, pc: fetch.pc_i};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        ex_valid_d = 1'b1;
        ex_ctrl_d  = dec_ctrl;
        ex_pc_d    = head.pc;
        ex_rs_d    = head_rs;
        ex_rt_d    = head_rt;
        ex_rd_d    = head_rd;
        ex_imm_d   = head_imm;
        if (dec_stop) stop_d = 1'b1;
      end else if (adv) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(issue);
    end
    id_ready_d = (count_d < CNT_W'(BUF_DEPTH)) && !stop_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_ready_q <= 1'b1;
      stop_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      id_ready_q <= id_ready_d;
      stop_q     <= stop_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_pc_q    <= ex_pc_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_imm_q   <= ex_imm_d;
    end
  end

  assign fetch.id_ready_o = id_ready_q;
  assign rf_r1_o     = head_valid ? head_rs : '0;
  assign rf_r2_o     = head_valid ? head_rt : '0;
  assign jump_o      = head_valid && dec_jump;
  assign jump_addr_o = head_valid ? head_imm : '0;
  assign stop_o      = stop_q;
  assign ex_valid_o  = ex_valid_q;
  assign pcE         = ex_pc_q;
  assign rsE         = ex_rs_q;
  assign rtE         = ex_rt_q;
  assign rdE         = ex_rd_q;
  assign imm8E       = ex_imm_q;
  assign RegWriteE   = ex_ctrl_q.reg_write;
  assign ALUopE      = ex_ctrl_q.alu_op;
  assign BranchE     = ex_ctrl_q.branch;
  assign MemReadE    = ex_ctrl_q.mem_read;
  assign RegDstE     = ex_ctrl_q.reg_dst;
  assign MemWriteE   = ex_ctrl_q.mem_write;
  assign MemToRegE   = ex_ctrl_q.mem_to_reg;
  assign MovE        = ex_ctrl_q.mov;
  assign FloatingE   = ex_ctrl_q.floating;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_stage_hs : directed stimulus against a queue-based stage model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_id_stage_hs;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       ex_ready = 1'b1;
  logic [3:0] rf_r1, rf_r2, rsE, rtE, rdE;
  logic       jump, stop, exv;
  logic [7:0] jaddr, pcE, imm8E;
  logic       RegWriteE, BranchE, MemReadE, RegDstE, MemWriteE, MemToRegE, MovE, FloatingE;
  logic [1:0] ALUopE;

  id_stage_hs_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) fif ();

  id_stage_hs dut (
    .clk(clk), .rst(rst), .flush_i(flush), .fetch(fif),
    .rf_r1_o(rf_r1), .rf_r2_o(rf_r2), .jump_o(jump), .jump_addr_o(jaddr),
    .stop_o(stop), .ex_valid_o(exv), .ex_ready_i(ex_ready),
    .pcE(pcE), .rsE(rsE), .rtE(rtE), .rdE(rdE), .imm8E(imm8E),
    .RegWriteE(RegWriteE), .ALUopE(ALUopE), .BranchE(BranchE), .MemReadE(MemReadE),
    .RegDstE(RegDstE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE), .MovE(MovE),
    .FloatingE(FloatingE)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] instr; logic [7:0] pc; } ent_t;
  ent_t        pend[$];
  ent_t        mq[$];
  logic        m_ready, m_stop, m_exv;
  logic [15:0] m_ex_instr;
  logic [7:0]  m_ex_pc;
  logic [9:0]  m_ctrl;
  int          total = 0;
  int          bad = 0;
  bit          live = 1'b0;

  // {RegWrite, ALUop[1:0], Branch, MemRead, RegDst, MemWrite, MemToReg, Mov, Floating}
  function automatic logic [9:0] ctrl_of(input logic [3:0] op);
    case (op)
      4'h1: return 10'b1_10_0_0_1_0_0_0_0;
      4'h2: return 10'b1_11_0_0_1_0_0_0_0;
      4'h3: return 10'b1_00_0_0_0_0_0_0_0;
      4'h4: return 10'b1_00_0_1_0_0_1_0_0;
      4'h5: return 10'b0_00_0_0_0_1_0_0_0;
      4'h6: return 10'b0_01_1_0_0_0_0_0_0;
      4'h8: return 10'b1_00_0_0_1_0_0_1_0;
      4'h9: return 10'b1_10_0_0_1_0_0_0_1;
      default: return 10'b0;
    endcase
  endfunction

  function automatic bit is_r(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h9);
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c};
  endfunction

  task automatic add_p(input logic [15:0] instr, input logic [7:0] pc);
    ent_t e;
    e.instr = instr;
    e.pc    = pc;
    pend.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the stage, described as queue/slot bookkeeping.
  task automatic model_step();
    bit   head_ok, adv, haz, iss, psh;
    ent_t h;
    if (rst) begin
      mq.delete();
      m_exv = 1'b0; m_stop = 1'b0; m_ctrl = '0; m_ex_instr = '0; m_ex_pc = '0; m_ready = 1'b1;
      return;
    end
    head_ok = (mq.size() != 0);
    adv     = !m_exv || ex_ready;
    haz     = 1'b0;
    if (head_ok && m_exv && m_ctrl[5]) begin
      h   = mq[0];
      haz = (m_ex_instr[7:4] == h.instr[11:8]) ||
            (is_r(h.instr[15:12]) && (m_ex_instr[7:4] == h.instr[7:4]));
    end
    iss = adv && head_ok && !haz && !m_stop;
    psh = fif.if_valid_i && m_ready;
    if (flush) begin
      mq.delete();
      m_exv  = 1'b0;
      m_ctrl = '0;
    end else begin
      if (iss) begin
        h          = mq.pop_front();
        m_exv      = 1'b1;
        m_ex_instr = h.instr;
        m_ex_pc    = h.pc;
        m_ctrl     = ctrl_of(h.instr[15:12]);
        if (h.instr[15:12] == 4'hF) m_stop = 1'b1;
      end else if (adv) begin
        m_exv  = 1'b0;
        m_ctrl = '0;
      end
      if (psh) begin
        h.instr = fif.instr_i;
        h.pc    = fif.pc_i;
        mq.push_back(h);
      end
    end
    m_ready = (mq.size() < 2) && !m_stop;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    live = 1'b1;
    #1;
  endtask

  task automatic drive(input int n, input logic rdy);
    bit acc;
    for (int c = 0; c < n; c++) begin
      ex_ready = rdy;
      if (pend.size() != 0) begin
        fif.if_valid_i = 1'b1;
        fif.instr_i    = pend[0].instr;
        fif.pc_i       = pend[0].pc;
      end else begin
        fif.if_valid_i = 1'b0;
      end
      acc = fif.if_valid_i && fif.id_ready_o;
      tick();
      if (acc) pend.delete(0);
    end
    fif.if_valid_i = 1'b0;
  endtask

  initial begin
    logic [15:0] h0;
    forever begin
      @(negedge clk);
      if (live) begin
        chk("id_ready", fif.id_ready_o, m_ready);
        chk("ex_valid", exv, m_exv);
        chk("stop", stop, m_stop);
        chk("ctrlE", {RegWriteE, ALUopE, BranchE, MemReadE, RegDstE, MemWriteE, MemToRegE, MovE, FloatingE}, m_ctrl);
        chk("pcE", pcE, m_ex_pc);
        chk("rsE", rsE, m_ex_instr[11:8]);
        chk("rtE", rtE, m_ex_instr[7:4]);
        chk("rdE", rdE, m_ex_instr[3:0]);
        chk("imm8E", imm8E, m_ex_instr[7:0]);
        if (mq.size() != 0) begin
          h0 = mq[0].instr;
          chk("rf_r1", rf_r1, h0[11:8]);
          chk("rf_r2", rf_r2, h0[7:4]);
          chk("jump", jump, h0[15:12] == 4'h7);
          chk("jump_addr", jaddr, h0[7:0]);
        end else begin
          chk("rf_r1_empty", rf_r1, 0);
          chk("rf_r2_empty", rf_r2, 0);
          chk("jump_empty", jump, 0);
        end
      end
    end
  end

  initial begin
    logic [19:0] pat;
    fif.if_valid_i = 1'b1;
    fif.instr_i    = mk(4'h1, 4'h1, 4'h2, 4'h3);
    fif.pc_i       = 8'h00;

    // Reset held two cycles with a valid fetch presented
    tick();
    tick();
    chk("rst_ex_valid", exv, 0);
    chk("rst_id_ready", fif.id_ready_o, 1);
    chk("rst_ctrl", {RegWriteE, MemReadE, MemWriteE, BranchE}, 0);
    chk("rst_no_push", rf_r1, 0);
    rst = 1'b0;
    fif.if_valid_i = 1'b0;
    drive(1, 1'b1);

    // Stream of three ADDs
    add_p(mk(4'h1, 4'h1, 4'h2, 4'h3), 8'd0);
    add_p(mk(4'h1, 4'h1, 4'h2, 4'h3), 8'd1);
    add_p(mk(4'h1, 4'h1, 4'h2, 4'h3), 8'd2);
    drive(1, 1'b1);
    drive(1, 1'b1);
    chk("stream_pc0", {exv, pcE}, {1'b1, 8'd0});
    drive(1, 1'b1);
    chk("stream_pc1", {exv, pcE}, {1'b1, 8'd1});
    drive(1, 1'b1);
    chk("stream_pc2", {exv, pcE}, {1'b1, 8'd2});
    chk("stream_ctrl", {RegWriteE, ALUopE, RegDstE}, 4'b1101);
    drive(2, 1'b1);

    // Load-use: LW r3 then ADD rs=r3
    add_p(mk(4'h4, 4'h0, 4'h3, 4'h0), 8'd8);
    add_p(mk(4'h1, 4'h3, 4'h1, 4'h2), 8'd9);
    drive(2, 1'b1);
    chk("lu_lw_in_ex", {exv, MemReadE, pcE}, {1'b1, 1'b1, 8'd8});
    drive(1, 1'b1);
    chk("lu_bubble", {exv, RegWriteE}, 2'b00);
    drive(1, 1'b1);
    chk("lu_add_issue", {exv, pcE}, {1'b1, 8'd9});
    // Same pair with rs=r4: no bubble
    add_p(mk(4'h4, 4'h0, 4'h3, 4'h0), 8'd10);
    add_p(mk(4'h1, 4'h4, 4'h1, 4'h2), 8'd11);
    drive(3, 1'b1);
    chk("lu_nohaz", {exv, pcE}, {1'b1, 8'd11});
    drive(2, 1'b1);

    // Backpressure: EX stalled for cycles 2..4
    for (int i = 0; i < 4; i++) add_p(mk(4'h1, 4'(i), 4'h5, 4'h6), 8'(20 + i));
    for (int c = 0; c < 10; c++) begin
      drive(1, (c < 2) || (c >= 5));
      if (c == 4) begin
        chk("bp_frozen", {exv, pcE}, {1'b1, 8'd20});
        chk("bp_full", fif.id_ready_o, 0);
      end
      if (c == 7) chk("bp_last", {exv, pcE}, {1'b1, 8'd23});
    end

    // Flush with FIFO full and EX valid
    for (int i = 0; i < 3; i++) add_p(mk(4'h3, 4'h1, 4'h2, 4'(i)), 8'(30 + i));
    drive(3, 1'b0);
    chk("fl_pre_full", {exv, fif.id_ready_o}, 2'b10);
    add_p(mk(4'h1, 4'h7, 4'h7, 4'h7), 8'd40);
    flush = 1'b1;
    drive(1, 1'b0);
    flush = 1'b0;
    pend.delete();
    chk("fl_ex_valid", exv, 0);
    chk("fl_ready", fif.id_ready_o, 1);
    chk("fl_empty", rf_r1, 0);
    drive(3, 1'b1);
    chk("fl_quiet", exv, 0);
    // Flush coinciding with an accepted push
    add_p(mk(4'h1, 4'h2, 4'h2, 4'h2), 8'd50);
    add_p(mk(4'h1, 4'h8, 4'h8, 4'h8), 8'd51);
    drive(1, 1'b1);
    flush = 1'b1;
    drive(1, 1'b1);
    flush = 1'b0;
    chk("fl2_ex_valid", exv, 0);
    drive(3, 1'b1);
    chk("fl2_dropped", {exv, rf_r1}, 0);

    // Mixed ops with varied EX readiness, then STOP
    add_p(mk(4'h4, 4'h0, 4'h5, 4'h0), 8'd60);
    add_p(mk(4'h2, 4'h1, 4'h5, 4'h2), 8'd61);
    add_p(mk(4'h5, 4'h2, 4'h5, 4'h0), 8'd62);
    add_p(mk(4'h7, 4'h0, 4'h7, 4'hA), 8'd63);
    add_p(mk(4'h6, 4'h1, 4'h2, 4'h4), 8'd64);
    add_p(mk(4'h8, 4'h3, 4'h0, 4'h6), 8'd65);
    add_p(mk(4'h9, 4'h1, 4'h2, 4'h3), 8'd66);
    add_p(16'hF000, 8'd67);
    add_p(mk(4'h1, 4'h9, 4'h8, 4'h7), 8'd68);
    pat = 20'b1011_0110_1101_0011_1010;
    for (int c = 0; c < 20; c++) drive(1, pat[c]);
    drive(16, 1'b1);
    chk("stop_set", stop, 1);
    chk("stop_ready", fif.id_ready_o, 0);
    chk("stop_bubble", exv, 0);
    chk("stop_pcE", pcE, 8'd67);
    chk("stop_fifo_kept", rf_r1, 4'h9);
    rst = 1'b1;
    drive(1, 1'b1);
    rst = 1'b0;
    chk("rst2_stop", stop, 0);
    chk("rst2_ready", fif.id_ready_o, 1);
    drive(2, 1'b1);
    chk("rst2_empty", {exv, rf_r1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
